mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported memory bus between the core's instruction-fetch requester and its load/store requester. Sits between the decoder/PC datapath and the memory bus. Each access is accepted from a held-level request, driven onto the bus, completed on the bus handshake, and returned as a one-cycle ready pulse. A watchdog aborts bus transfers that never complete.

## Interface
- DATA_WIDTH, 32, data width; bus_be_o is DATA_WIDTH/8 bits
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 255, cycles a bus transfer may wait for bus_ready_i before abort; legal range 1..65535
- clk_i  in  1  single clock, all logic on rising edge
- reset_i  in  1  reset; one clock; asynchronous, active-high
- imem_req_i  in  1  fetch request level, held until imem_ready_o
- imem_addr_i  in  ADDR_WIDTH  fetch address
- imem_data_o  out  DATA_WIDTH  fetched word, valid with imem_ready_o and held until next fetch completes
- imem_ready_o  out  1  one-cycle completion pulse
- dmem_rd_en_i  in  1  load request level, held until dmem_ready_o
- dmem_wr_en_i  in  1  store request level, held until dmem_ready_o
- dmem_addr_i  in  ADDR_WIDTH  load/store address
- dmem_wdata_i  in  DATA_WIDTH  store data
- dmem_be_i  in  DATA_WIDTH/8  store byte enables
- dmem_rdata_o  out  DATA_WIDTH  load data, valid with dmem_ready_o
- dmem_ready_o  out  1  one-cycle completion pulse
- bus_req_o  out  1  bus transfer active
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_WIDTH  bus address
- bus_wdata_o  out  DATA_WIDTH  bus write data
- bus_be_o  out  DATA_WIDTH/8  byte enables; all ones for reads
- bus_rdata_i  in  DATA_WIDTH  bus read data, sampled when bus_ready_i = 1
- bus_ready_i  in  1  transfer completion
- arb_err_o  out  1  one-cycle pulse, coincident with the requester ready pulse, when a transfer was aborted by timeout

## Operation
- FSM has four states.
  - ARB_IDLE: no transfer active.
  - ARB_IMEM: fetch transfer on the bus.
  - ARB_DMEM: load/store transfer on the bus.
  - ARB_RESP: requester ready pulse is driven.
- Transitions
  - ARB_IDLE -> ARB_IMEM or ARB_DMEM on a pending request.
  - ARB_IMEM/ARB_DMEM -> ARB_RESP on bus_ready_i or on timeout.
  - ARB_RESP -> ARB_IDLE unconditionally.
- Grant (ARB_IDLE only), fixed priority: dmem over imem.
- Grant action: register the bus outputs from the granted requester's inputs. Bus outputs stay stable until the transfer ends; later changes on the requester inputs are ignored.
- If dmem_rd_en_i and dmem_wr_en_i are both 1, the access is a write.
- Completion: rdata is captured into the owner's data register (imem_data_o or dmem_rdata_o). A store leaves dmem_rdata_o unchanged.
- Response: in ARB_RESP, pulse the owner's ready_o for exactly one cycle. ARB_RESP guarantees the still-held request is not regranted in the same cycle. The requester drops its request on seeing ready.
- Watchdog: counter cleared on grant, incremented each cycle in ARB_IMEM/ARB_DMEM. If it reaches TIMEOUT_CYCLES without bus_ready_i:
  - drop bus_req_o;
  - load 32'hDEAD_BEEF, zero-extended or truncated to DATA_WIDTH, into the owner's data register (read transfers only);
  - pulse ready_o and arb_err_o in ARB_RESP.
- If bus_ready_i arrives in the same cycle the counter reaches the limit, the transfer completes normally; no error.

## Timing
- Reset values: all outputs 0, data registers 0, FSM ARB_IDLE, counter 0.
- Reset mid-transfer drops the transfer immediately. No ready pulse follows.
- Request seen at cycle 0 (in ARB_IDLE) -> bus_req_o = 1 from cycle 1.
- bus_ready_i at cycle k (k >= 1) -> bus_req_o = 0 and ready_o = 1 at cycle k+1.
- Earliest turnaround: request cycle 0, ready cycle 2, next grant sampled cycle 3, next bus_req_o cycle 4.
- bus_req_o is 1 on every cycle of ARB_IMEM/ARB_DMEM, including the cycle where bus_ready_i arrives.
- No combinational path from any requester or bus input to any output; all outputs are registered.

## Configuration
- MEM_ARB_RR_EN defined: round-robin grant. A last-owner register is updated on every grant. When both requesters are pending in ARB_IDLE, the one not granted last wins.
- MEM_ARB_RR_EN not defined: fixed dmem-over-imem priority, and no last-owner register is built.

## Structure
- Package mem_arb_pkg:
  - state enum (ARB_IDLE, ARB_IMEM, ARB_DMEM, ARB_RESP);
  - owner enum (OWN_IMEM, OWN_DMEM);
  - ARB_ABORT_DATA = 32'hDEAD_BEEF.
- Sub-module mem_arb_watchdog holds the TIMEOUT_CYCLES counter.
  - Inputs: clear, enable.
  - Output: expired pulse.

## Test plan
- Lone fetch, addr 0x100, bus_ready_i 2 cycles after bus_req_o with rdata 0x00500093 -> one imem_ready_o pulse, imem_data_o = 0x00500093, bus_we_o = 0.
- Store 0xCAFEF00D to 0x2000 with be 4'b0011 -> bus_we_o = 1, bus_be_o = 4'b0011, dmem_ready_o pulse, dmem_rdata_o unchanged.
- imem_req_i and dmem_rd_en_i both raised in the same cycle -> dmem served first, then imem. With MEM_ARB_RR_EN, two back-to-back contentions alternate owners.
- TIMEOUT_CYCLES = 4, bus_ready_i held 0 -> bus_req_o dropped after 4 cycles, dmem_rdata_o = 0xDEADBEEF, dmem_ready_o and arb_err_o pulse together.
- reset_i asserted while bus_req_o = 1 -> all outputs 0 immediately; no ready pulse. After release, a held imem_req_i is granted afresh.
- Request held high through its ready pulse -> exactly one transfer per request. The next bus_req_o rises no earlier than 2 cycles after the ready pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IMEM = 2'd1,
        ARB_DMEM = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } arb_owner_e;

    // Word returned to a reader whose bus transfer was aborted by the watchdog
    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

    // Watchdog counter width, wide enough for TIMEOUT_CYCLES up to 65535
    localparam int unsigned ARB_CNT_W = 16;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus transfer watchdog: counts busy cycles and flags the last allowed cycle.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c_o
);

    logic [ARB_CNT_W-1:0] cnt_q;

    // Counter restarts on grant and advances once per busy cycle
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_c_o) begin
            cnt_q <= cnt_q + ARB_CNT_W'(1);
        end
    end

    // Counter reaches TIMEOUT_CYCLES on the coming edge
    assign expired_c_o = enable_i && (cnt_q == ARB_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store requesters onto one memory bus.
// Optional round-robin grant is enabled by defining MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    imem_req_i,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    output logic [DATA_WIDTH-1:0]   imem_data_o,
    output logic                    imem_ready_o,
    input  logic                    dmem_rd_en_i,
    input  logic                    dmem_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_be_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    input  logic                    bus_ready_i,
    output logic                    arb_err_o
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    arb_state_e            state_q;
    logic                  bus_req_q;
    logic                  bus_we_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic [BE_W-1:0]       bus_be_q;
    logic [DATA_WIDTH-1:0] imem_data_q;
    logic [DATA_WIDTH-1:0] dmem_rdata_q;
    logic                  imem_ready_q;
    logic                  dmem_ready_q;
    logic                  err_q;

    logic                  imem_pend;
    logic                  dmem_pend;
    logic                  grant_dmem;
    logic                  wd_clear;
    logic                  wd_enable;
    logic                  wd_expired;
    logic                  xfer_done;
    logic [DATA_WIDTH-1:0] done_data;

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_owner_q;

    // Remember the most recent grant winner for round-robin tie-breaks
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_owner_q <= OWN_IMEM;
        end else if (state_q == ARB_IDLE && (imem_pend || dmem_pend)) begin
            last_owner_q <= grant_dmem ? OWN_DMEM : OWN_IMEM;
        end
    end
`endif

    // Grant decision and transfer-completion terms
    always_comb begin
        imem_pend  = imem_req_i;
        dmem_pend  = dmem_rd_en_i || dmem_wr_en_i;
`ifdef MEM_ARB_RR_EN
        grant_dmem = dmem_pend && (!imem_pend || last_owner_q == OWN_IMEM);
`else
        grant_dmem = dmem_pend;
`endif
        wd_clear   = (state_q == ARB_IDLE) && (imem_pend || dmem_pend);
        wd_enable  = (state_q == ARB_IMEM) || (state_q == ARB_DMEM);
        xfer_done  = bus_ready_i || wd_expired;
        done_data  = bus_ready_i ? bus_rdata_i : DATA_WIDTH'(ARB_ABORT_DATA);
    end

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (wd_clear),
        .enable_i   (wd_enable),
        .expired_c_o(wd_expired)
    );

    // Arbiter FSM with registered bus and requester outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ARB_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            imem_data_q  <= '0;
            dmem_rdata_q <= '0;
            imem_ready_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_ready_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_dmem) begin
                        state_q     <= ARB_DMEM;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= dmem_wr_en_i;
                        bus_addr_q  <= dmem_addr_i;
                        bus_wdata_q <= dmem_wdata_i;
                        bus_be_q    <= dmem_wr_en_i ? dmem_be_i : '1;
                    end else if (imem_pend) begin
                        state_q     <= ARB_IMEM;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= imem_addr_i;
                        bus_wdata_q <= '0;
                        bus_be_q    <= '1;
                    end
                end
                ARB_IMEM: begin
                    if (xfer_done) begin
                        state_q      <= ARB_RESP;
                        bus_req_q    <= 1'b0;
                        imem_data_q  <= done_data;
                        imem_ready_q <= 1'b1;
                        err_q        <= !bus_ready_i;
                    end
                end
                ARB_DMEM: begin
                    if (xfer_done) begin
                        state_q      <= ARB_RESP;
                        bus_req_q    <= 1'b0;
                        dmem_ready_q <= 1'b1;
                        err_q        <= !bus_ready_i;
                        if (!bus_we_q) begin
                            dmem_rdata_q <= done_data;
                        end
                    end
                end
                ARB_RESP: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign imem_data_o  = imem_data_q;
    assign imem_ready_o = imem_ready_q;
    assign dmem_rdata_o = dmem_rdata_q;
    assign dmem_ready_o = dmem_ready_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_be_o     = bus_be_q;
    assign arb_err_o    = err_q;

endmodule
